fwd_hazard_unit: RTL and testbench

- Parametrised successor of the EX-stage ALU operand forwarding mux: N_OPERANDS operand muxes, select generation from pipeline register tags, and a load-use stall FSM for memories with configurable latency.
- Sits between the ID/EX pipeline register and the ALU. It drives stall/bubble to the PC, IF/ID and ID/EX control, and exposes a forwarding-hit performance counter for the debug unit.

---
 rtl/fwd_hazard_unit_pkg.sv | 13 +
 rtl/fwd_hazard_unit_mux.sv | 39 +++
 rtl/fwd_hazard_unit.sv | 126 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding and load-use hazard unit.
package fwd_hazard_unit_pkg;
  localparam logic [1:0] SEL_REG   = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  localparam int REG_ZERO = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;
endpackage

// File: rtl/fwd_hazard_unit_mux.sv
// Single-operand forwarding select and data mux; EX/MEM beats MEM/WB, r0 never forwards.
module fwd_operand_mux
  import fwd_hazard_unit_pkg::*;
#(
  parameter int LEN_DATA = 32,
  parameter int NB_REG   = 5
) (
  input  logic [NB_REG-1:0]   src,
  input  logic [LEN_DATA-1:0] reg_data,
  input  logic [NB_REG-1:0]   exmem_rd,
  input  logic                exmem_regwrite,
  input  logic [LEN_DATA-1:0] exmem_alu,
  input  logic [NB_REG-1:0]   memwb_rd,
  input  logic                memwb_regwrite,
  input  logic [LEN_DATA-1:0] memwb_data,
  output logic [1:0]          sel,
  output logic [LEN_DATA-1:0] data
);
  logic src_nz;

  assign src_nz = (src != NB_REG'(REG_ZERO));

  always_comb begin
    sel = SEL_REG;
    if (exmem_regwrite && (exmem_rd == src) && src_nz) begin
      sel = SEL_EXMEM;
    end else if (memwb_regwrite && (memwb_rd == src) && src_nz) begin
      sel = SEL_MEMWB;
    end
  end

  always_comb begin
    case (sel)
      SEL_EXMEM: data = exmem_alu;
      SEL_MEMWB: data = memwb_data;
      default:   data = reg_data;
    endcase
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding, load-use stall FSM and saturating forwarding-hit counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int LEN_DATA     = 32,
  parameter int NB_REG       = 5,
  parameter int N_OPERANDS   = 2,
  parameter int LOAD_LATENCY = 1,
  parameter int LEN_CNT      = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_OPERANDS*NB_REG-1:0] ex_src_reg,
  input  logic [N_OPERANDS*LEN_DATA-1:0] ex_src_data,
  input  logic [NB_REG-1:0]            exmem_rd,
  input  logic                         exmem_regwrite,
  input  logic [LEN_DATA-1:0]          exmem_alu,
  input  logic [NB_REG-1:0]            memwb_rd,
  input  logic                         memwb_regwrite,
  input  logic [LEN_DATA-1:0]          memwb_data,
  input  logic [NB_REG-1:0]            id_rs,
  input  logic [NB_REG-1:0]            id_rt,
  input  logic                         idex_memread,
  input  logic [NB_REG-1:0]            idex_rd,
  input  logic                         flush,
  input  logic                         cnt_clear,
  output logic [N_OPERANDS*LEN_DATA-1:0] fwd_data,
  output logic [N_OPERANDS*2-1:0]      fwd_sel,
  output logic                         stall,
  output logic                         bubble,
  output logic [LEN_CNT-1:0]           fwd_hits
);
  localparam int CNT_W = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY + 1) : 1;
  localparam int HIT_W = (N_OPERANDS > 1) ? $clog2(N_OPERANDS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LOAD_LATENCY > 1) ? LOAD_LATENCY - 2 : 0);

  hz_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hz;
  logic             stall_c;
  logic [HIT_W-1:0] hit_cnt;

  function automatic logic [LEN_CNT-1:0] sat_add(input logic [LEN_CNT-1:0] a,
                                                 input logic [HIT_W-1:0]   b);
    logic [LEN_CNT:0] s;
    s = {1'b0, a} + (LEN_CNT+1)'(b);
    return s[LEN_CNT] ? {LEN_CNT{1'b1}} : s[LEN_CNT-1:0];
  endfunction

  for (genvar k = 0; k < N_OPERANDS; k++) begin : g_op
    fwd_operand_mux #(
      .LEN_DATA(LEN_DATA),
      .NB_REG  (NB_REG)
    ) u_mux (
      .src           (ex_src_reg[k*NB_REG +: NB_REG]),
      .reg_data      (ex_src_data[k*LEN_DATA +: LEN_DATA]),
      .exmem_rd      (exmem_rd),
      .exmem_regwrite(exmem_regwrite),
      .exmem_alu     (exmem_alu),
      .memwb_rd      (memwb_rd),
      .memwb_regwrite(memwb_regwrite),
      .memwb_data    (memwb_data),
      .sel           (fwd_sel[k*2 +: 2]),
      .data          (fwd_data[k*LEN_DATA +: LEN_DATA])
    );
  end

  assign hz = idex_memread && (idex_rd != NB_REG'(REG_ZERO)) &&
              ((idex_rd == id_rs) || (idex_rd == id_rt));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    if (flush) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hz) begin
            stall_c = 1'b1;
            if (LOAD_LATENCY > 1) begin
              state_nxt = ST_STALL;
              cnt_nxt   = CNT_LOAD;
            end
          end
        end
        ST_STALL: begin
          stall_c = 1'b1;
          if (cnt == '0) state_nxt = ST_IDLE;
          else           cnt_nxt   = cnt - CNT_W'(1);
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps the pipeline free-running while reset is held,
  // even if a hazard is still present on the inputs.
  assign stall  = stall_c & rst_n;
  assign bubble = stall;

  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < N_OPERANDS; k++) begin
      if (fwd_sel[k*2 +: 2] != SEL_REG) hit_cnt = hit_cnt + HIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fwd_hits <= '0;
    else if (cnt_clear) fwd_hits <= '0;
    else if (!stall)    fwd_hits <= sat_add(fwd_hits, hit_cnt);
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with LOAD_LATENCY=3 and a 4-bit hit counter.
module tb_fwd_hazard_unit;
  localparam int LEN_DATA = 32;
  localparam int NB_REG   = 5;
  localparam int N_OP     = 2;
  localparam int LL       = 3;
  localparam int LEN_CNT  = 4;

  logic                       clk;
  logic                       rst_n;
  logic [NB_REG-1:0]          src0, src1;
  logic [LEN_DATA-1:0]        dat0, dat1;
  logic [N_OP*NB_REG-1:0]     ex_src_reg;
  logic [N_OP*LEN_DATA-1:0]   ex_src_data;
  logic [NB_REG-1:0]          exmem_rd, memwb_rd, id_rs, id_rt, idex_rd;
  logic                       exmem_regwrite, memwb_regwrite, idex_memread, flush, cnt_clear;
  logic [LEN_DATA-1:0]        exmem_alu, memwb_data;
  logic [N_OP*LEN_DATA-1:0]   fwd_data;
  logic [N_OP*2-1:0]          fwd_sel;
  logic                       stall, bubble;
  logic [LEN_CNT-1:0]         fwd_hits;

  int vectors;
  int miscompares;

  assign ex_src_reg  = {src1, src0};
  assign ex_src_data = {dat1, dat0};

  fwd_hazard_unit #(
    .LEN_DATA(LEN_DATA), .NB_REG(NB_REG), .N_OPERANDS(N_OP),
    .LOAD_LATENCY(LL), .LEN_CNT(LEN_CNT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_src_reg(ex_src_reg), .ex_src_data(ex_src_data),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_alu(exmem_alu),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_data(memwb_data),
    .id_rs(id_rs), .id_rt(id_rt), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .flush(flush), .cnt_clear(cnt_clear),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble),
    .fwd_hits(fwd_hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic quiet_inputs();
    src0 = '0; src1 = '0; dat0 = '0; dat1 = '0;
    exmem_rd = '0; exmem_regwrite = 1'b0; exmem_alu = '0;
    memwb_rd = '0; memwb_regwrite = 1'b0; memwb_data = '0;
    id_rs = '0; id_rt = '0; idex_memread = 1'b0; idex_rd = '0;
    flush = 1'b0; cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    quiet_inputs();
    idex_memread = 1'b1; idex_rd = 5'd4; id_rt = 5'd4;
    #3;
    vectors++;
    if (stall !== 1'b0 || bubble !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: stall=%b bubble=%b expected 0 0", stall, bubble);
    end
    vectors++;
    if (fwd_hits !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_hits: got %0d expected 0", fwd_hits);
    end
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    @(negedge clk);
    cnt_clear = 1'b1;
    src0 = 5'd3; src1 = 5'd5; dat0 = 32'h44; dat1 = 32'h55;
    exmem_rd = 5'd3; exmem_regwrite = 1'b1; exmem_alu = 32'h11;
    memwb_rd = 5'd3; memwb_regwrite = 1'b1; memwb_data = 32'h22;
    #1;
    vectors++;
    if (fwd_sel !== 4'b0001 || fwd_data !== {32'h55, 32'h11}) begin
      miscompares++;
      $display("FAIL exmem_priority: sel=%b data=%h expected 0001 %h", fwd_sel, fwd_data, {32'h55, 32'h11});
    end
    memwb_rd = 5'd5;
    #1;
    vectors++;
    if (fwd_sel !== 4'b1001 || fwd_data !== {32'h22, 32'h11}) begin
      miscompares++;
      $display("FAIL mixed_sources: sel=%b data=%h expected 1001 %h", fwd_sel, fwd_data, {32'h22, 32'h11});
    end
    exmem_regwrite = 1'b0; memwb_rd = 5'd3;
    #1;
    vectors++;
    if (fwd_sel !== 4'b0010 || fwd_data !== {32'h55, 32'h22}) begin
      miscompares++;
      $display("FAIL memwb_only: sel=%b data=%h expected 0010 %h", fwd_sel, fwd_data, {32'h55, 32'h22});
    end
  endtask

  task automatic test_reg_zero();
    @(negedge clk);
    quiet_inputs();
    dat0 = 32'hAAAA_5555; dat1 = 32'h1234_5678;
    exmem_rd = 5'd0; exmem_regwrite = 1'b1; exmem_alu = 32'h11;
    memwb_rd = 5'd0; memwb_regwrite = 1'b1; memwb_data = 32'h22;
    #1;
    vectors++;
    if (fwd_sel !== 4'b0000 || fwd_data !== {32'h1234_5678, 32'hAAAA_5555}) begin
      miscompares++;
      $display("FAIL reg_zero_pass: sel=%b data=%h expected 0000 %h", fwd_sel, fwd_data, {32'h1234_5678, 32'hAAAA_5555});
    end
    @(negedge clk);
    vectors++;
    if (fwd_hits !== 4'd0) begin
      miscompares++;
      $display("FAIL reg_zero_hits: got %0d expected 0", fwd_hits);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    quiet_inputs();
    idex_memread = 1'b1; idex_rd = 5'd7; id_rs = 5'd7;
    src0 = 5'd3; exmem_rd = 5'd3; exmem_regwrite = 1'b1;
    for (int c = 1; c <= LL; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      vectors++;
      if (stall !== 1'b1 || bubble !== 1'b1) begin
        miscompares++;
        $display("FAIL load_use_cycle%0d: stall=%b bubble=%b expected 1 1", c, stall, bubble);
      end
    end
    @(negedge clk);
    quiet_inputs();
    #1;
    vectors++;
    if (stall !== 1'b0 || bubble !== 1'b0) begin
      miscompares++;
      $display("FAIL load_use_end: stall=%b bubble=%b expected 0 0", stall, bubble);
    end
    vectors++;
    if (fwd_hits !== 4'd0) begin
      miscompares++;
      $display("FAIL stall_blocks_hits: got %0d expected 0", fwd_hits);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    quiet_inputs();
    idex_memread = 1'b1; idex_rd = 5'd9; id_rt = 5'd9;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_hz_start: stall=%b expected 1", stall);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    vectors++;
    if (stall !== 1'b0 || bubble !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_kills_stall: stall=%b bubble=%b expected 0 0", stall, bubble);
    end
    @(negedge clk);
    quiet_inputs();
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_back_idle: stall=%b expected 0", stall);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    quiet_inputs();
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    src0 = 5'd2; src1 = 5'd6;
    exmem_rd = 5'd2; exmem_regwrite = 1'b1;
    memwb_rd = 5'd6; memwb_regwrite = 1'b1;
    @(negedge clk);
    vectors++;
    if (fwd_hits !== 4'd2) begin
      miscompares++;
      $display("FAIL hits_before_reset: got %0d expected 2", fwd_hits);
    end
    quiet_inputs();
    idex_memread = 1'b1; idex_rd = 5'd8; id_rs = 5'd8;
    @(negedge clk);
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_stall: stall=%b expected 1", stall);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b0 || bubble !== 1'b0 || fwd_hits !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset: stall=%b bubble=%b hits=%0d expected 0 0 0", stall, bubble, fwd_hits);
    end
    @(negedge clk);
    quiet_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: stall=%b expected 0", stall);
    end
  endtask

  task automatic test_saturate();
    int exp_hits;
    @(negedge clk);
    quiet_inputs();
    cnt_clear = 1'b1;
    @(negedge clk);
    cnt_clear = 1'b0;
    src0 = 5'd10; src1 = 5'd11;
    exmem_rd = 5'd10; exmem_regwrite = 1'b1;
    memwb_rd = 5'd11; memwb_regwrite = 1'b1;
    vectors++;
    if (fwd_hits !== 4'd0) begin
      miscompares++;
      $display("FAIL sat_cleared: got %0d expected 0", fwd_hits);
    end
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp_hits = (2 * i > 15) ? 15 : 2 * i;
      vectors++;
      if (fwd_hits !== 4'(exp_hits)) begin
        miscompares++;
        $display("FAIL sat_step%0d: got %0d expected %0d", i, fwd_hits, exp_hits);
      end
    end
    cnt_clear = 1'b1;
    @(negedge clk);
    vectors++;
    if (fwd_hits !== 4'd0) begin
      miscompares++;
      $display("FAIL clear_priority: got %0d expected 0", fwd_hits);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_priority();
    test_reg_zero();
    test_load_use();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
